// File: rtl/qcalc_pkg.sv
// Shared types for the queue-calculator sequencer: opcodes, FSM states,
// completion codes and the stored program word.
package qcalc_pkg;

  localparam int unsigned QcalcWidth = 8;

  typedef enum logic [2:0] {
    OpPush = 3'd0,
    OpPop  = 3'd1,
    OpAdd  = 3'd2,
    OpMul  = 3'd3,
    OpSub  = 3'd4,
    OpDiv  = 3'd5,
    OpMod  = 3'd6
  } qcalc_op_e;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StIssue,
    StCheck,
    StFinish
  } seq_state_e;

  typedef enum logic [1:0] {
    ErrOk         = 2'd0,
    ErrRejected   = 2'd1,
    ErrEmptyProg  = 2'd2,
    ErrEmptyQueue = 2'd3
  } seq_err_e;

  // Op kept as raw bits so the unassigned code 7 can still be stored and issued.
  typedef struct packed {
    logic [2:0]            op;
    logic [QcalcWidth-1:0] data;
  } prog_word_t;

endpackage

// File: rtl/qcalc_sequencer_if.sv
// Link between the sequencer (master) and the queue calculator (slave).
interface qcalc_sequencer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             cq_reset;
  logic             cq_apply;
  logic [2:0]       cq_op;
  logic [WIDTH-1:0] cq_in;
  logic [WIDTH-1:0] cq_tail;
  logic             cq_valid;
  logic             cq_empty;

  modport master (
    output cq_reset, cq_apply, cq_op, cq_in,
    input  cq_tail, cq_valid, cq_empty
  );

  modport slave (
    input  cq_reset, cq_apply, cq_op, cq_in,
    output cq_tail, cq_valid, cq_empty
  );
endinterface

// File: rtl/qseq_prog_mem.sv
// Program store: Depth x (3+WIDTH) register file, one synchronous write port
// and one combinational read port. No reset, contents survive a sequencer reset.
module qseq_prog_mem #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned Depth = 16,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [WIDTH+2:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [WIDTH+2:0] rdata_o
);

  logic [WIDTH+2:0] mem_q [Depth];

  // Write port
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/qcalc_sequencer.sv
// Runs a stored program of queue-calculator operations and reports the outcome.
// Optional single-step control is built when QSEQ_STEP_EN is defined.
module qcalc_sequencer
  import qcalc_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PROG_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
`ifdef QSEQ_STEP_EN
  input  logic                          step_mode,
  input  logic                          step,
`endif
  input  logic                          load_valid,
  output logic                          load_ready,
  input  logic [2:0]                    load_op,
  input  logic [WIDTH-1:0]              load_data,
  input  logic                          clear_prog,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic [1:0]                    err_code,
  output logic [$clog2(PROG_DEPTH)-1:0] err_pc,
  output logic [WIDTH-1:0]              result,
  output logic [$clog2(PROG_DEPTH):0]   prog_len,
  qcalc_sequencer_if.master             cq
);

  localparam int unsigned PcW  = $clog2(PROG_DEPTH);
  localparam int unsigned LenW = PcW + 1;
  localparam logic [LenW-1:0] DepthLen = LenW'(PROG_DEPTH);

  seq_state_e       state_q, state_d;
  logic [PcW-1:0]   pc_q, pc_d;
  logic [LenW-1:0]  prog_len_q, prog_len_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  seq_err_e         err_code_q, err_code_d;
  logic [PcW-1:0]   err_pc_q, err_pc_d;
  logic [WIDTH-1:0] result_q, result_d;
  // An empty-program run spends one extra cycle in FINISH so every run
  // shares the same 2+2*len start-to-done latency.
  logic             hold_q, hold_d;

  logic             mem_we;
  logic [WIDTH+2:0] rd_word;
  logic [2:0]       rd_op;
  logic [WIDTH-1:0] rd_data;
  logic             is_last;
  logic             issue_go;

  qseq_prog_mem #(
    .WIDTH (WIDTH),
    .Depth (PROG_DEPTH)
  ) u_prog_mem (
    .clk_i   (clk),
    .we_i    (mem_we),
    .waddr_i (prog_len_q[PcW-1:0]),
    .wdata_i ({load_op, load_data}),
    .raddr_i (pc_q),
    .rdata_o (rd_word)
  );

  assign {rd_op, rd_data} = rd_word;
  assign is_last = ({1'b0, pc_q} == (prog_len_q - LenW'(1)));

`ifdef QSEQ_STEP_EN
  assign issue_go = !step_mode || step;
`else
  assign issue_go = 1'b1;
`endif

  // Next-state, datapath updates and calculator drive
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    prog_len_d  = prog_len_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_code_d  = err_code_q;
    err_pc_d    = err_pc_q;
    result_d    = result_q;
    hold_d      = hold_q;
    load_ready  = 1'b0;
    mem_we      = 1'b0;
    cq.cq_reset = 1'b0;
    cq.cq_apply = 1'b0;
    cq.cq_op    = rd_op;
    cq.cq_in    = rd_data;

    unique case (state_q)
      StIdle: begin
        load_ready = (prog_len_q < DepthLen) && !start && !clear_prog;
        if (start) begin
          pc_d       = '0;
          busy_d     = 1'b1;
          err_code_d = ErrOk;
          err_pc_d   = '0;
          result_d   = '0;
          if (prog_len_q == '0) begin
            err_code_d = ErrEmptyProg;
            hold_d     = 1'b1;
            state_d    = StFinish;
          end else begin
            state_d = StClear;
          end
        end else if (clear_prog) begin
          prog_len_d = '0;
        end else if (load_valid && load_ready) begin
          mem_we     = 1'b1;
          prog_len_d = prog_len_q + LenW'(1);
        end
      end
      StClear: begin
        cq.cq_reset = 1'b1;
        state_d     = StIssue;
      end
      StIssue: begin
        if (issue_go) begin
          cq.cq_apply = 1'b1;
          state_d     = StCheck;
        end
      end
      StCheck: begin
        if (!cq.cq_valid) begin
          err_code_d = ErrRejected;
          err_pc_d   = pc_q;
          state_d    = StFinish;
        end else if (is_last) begin
          if (cq.cq_empty) begin
            err_code_d = ErrEmptyQueue;
          end else begin
            err_code_d = ErrOk;
            result_d   = cq.cq_tail;
          end
          state_d = StFinish;
        end else begin
          pc_d    = pc_q + PcW'(1);
          state_d = StIssue;
        end
      end
      StFinish: begin
        if (hold_q) begin
          hold_d = 1'b0;
        end else begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      pc_q       <= '0;
      prog_len_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_code_q <= ErrOk;
      err_pc_q   <= '0;
      result_q   <= '0;
      hold_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      prog_len_q <= prog_len_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_code_q <= err_code_d;
      err_pc_q   <= err_pc_d;
      result_q   <= result_d;
      hold_q     <= hold_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err_code = err_code_q;
  assign err_pc   = err_pc_q;
  assign result   = result_q;
  assign prog_len = prog_len_q;

endmodule

// File: tb/tb_qcalc_sequencer.sv
// Bench for qcalc_sequencer with a behavioural five-entry queue calculator.
module tb_qcalc_sequencer;
  import qcalc_pkg::*;

  localparam int unsigned W   = 8;
  localparam int unsigned Cap = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_valid;
  logic       load_ready;
  logic [2:0] load_op;
  logic [W-1:0] load_data;
  logic       clear_prog;
  logic       start;
  logic       busy;
  logic       done;
  logic [1:0] err_code;
  logic [3:0] err_pc;
  logic [W-1:0] result;
  logic [4:0] prog_len;

  qcalc_sequencer_if #(.WIDTH(W)) cq ();

  qcalc_sequencer #(
    .WIDTH      (W),
    .PROG_DEPTH (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef QSEQ_STEP_EN
    .step_mode  (1'b0),
    .step       (1'b0),
`endif
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_op    (load_op),
    .load_data  (load_data),
    .clear_prog (clear_prog),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .err_code   (err_code),
    .err_pc     (err_pc),
    .result     (result),
    .prog_len   (prog_len),
    .cq         (cq)
  );

  always #5 clk = ~clk;

  // Calculator model: FIFO with head at byte 0; binary ops pop x then y and
  // push y op x at the tail; pushes beyond Cap, short queues, divide by zero
  // and op 7 are rejected.
  logic [Cap*W-1:0] q_vec, n_vec;
  int unsigned      q_cnt, n_cnt;
  logic             n_ok;
  logic [W-1:0]     cx, cy, cr;
  logic             calc_valid;

  always_comb begin
    n_vec = q_vec;
    n_cnt = q_cnt;
    n_ok  = 1'b0;
    cx    = q_vec[W-1:0];
    cy    = q_vec[2*W-1:W];
    cr    = '0;
    unique case (cq.cq_op)
      3'd0: if (q_cnt < Cap) begin
        n_vec[q_cnt*W +: W] = cq.cq_in;
        n_cnt = q_cnt + 1;
        n_ok  = 1'b1;
      end
      3'd1: if (q_cnt > 0) begin
        n_vec = q_vec >> W;
        n_cnt = q_cnt - 1;
        n_ok  = 1'b1;
      end
      3'd2, 3'd3, 3'd4, 3'd5, 3'd6: if (q_cnt >= 2) begin
        n_ok = 1'b1;
        case (cq.cq_op)
          3'd2: cr = cy + cx;
          3'd3: cr = cy * cx;
          3'd4: cr = cy - cx;
          3'd5: if (cx == 0) n_ok = 1'b0; else cr = cy / cx;
          default: if (cx == 0) n_ok = 1'b0; else cr = cy % cx;
        endcase
        if (n_ok) begin
          n_vec = q_vec >> (2 * W);
          n_vec[(q_cnt-2)*W +: W] = cr;
          n_cnt = q_cnt - 1;
        end
      end
      default: n_ok = 1'b0;
    endcase
  end

  always @(posedge clk or posedge reset) begin
    if (reset || cq.cq_reset) begin
      q_vec      <= '0;
      q_cnt      <= 0;
      calc_valid <= 1'b0;
    end else if (cq.cq_apply) begin
      calc_valid <= n_ok;
      if (n_ok) begin
        q_vec <= n_vec;
        q_cnt <= n_cnt;
      end
    end
  end

  assign cq.cq_valid = calc_valid;
  assign cq.cq_empty = (q_cnt == 0);
  assign cq.cq_tail  = (q_cnt == 0) ? '0 : q_vec[(q_cnt-1)*W +: W];

  // Pulse counters for calculator control strobes
  int n_app = 0;
  int n_rst = 0;
  always @(posedge clk) begin
    if (cq.cq_apply) n_app <= n_app + 1;
    if (cq.cq_reset) n_rst <= n_rst + 1;
  end

  typedef struct {
    int         lat;
    logic [1:0] err;
    logic [3:0] pc;
    logic [W-1:0] res;
    int         apps;
    int         rsts;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [2:0] op, input logic [W-1:0] d);
    @(negedge clk);
    load_valid = 1'b1;
    load_op    = op;
    load_data  = d;
    chk("load_ready", 32'(load_ready), 1);
    @(posedge clk);
    #1 load_valid = 1'b0;
  endtask

  task automatic clear();
    @(negedge clk);
    clear_prog = 1'b1;
    @(posedge clk);
    #1 clear_prog = 1'b0;
  endtask

  function automatic exp_t mk(int lat, logic [1:0] err, logic [3:0] pc, logic [W-1:0] res,
                              int apps, int rsts);
    exp_t e;
    e.lat = lat; e.err = err; e.pc = pc; e.res = res; e.apps = apps; e.rsts = rsts;
    return e;
  endfunction

  // Start a run and compare the completion against the oldest scoreboard entry.
  // With poke set, start and clear_prog are pulsed mid-run and must be ignored.
  task automatic run(input exp_t e, input bit poke);
    int   k;
    bit   seen;
    int   app0;
    int   rst0;
    exp_t got;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b1;
    app0  = n_app;
    rst0  = n_rst;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
    k    = 0;
    seen = 1'b0;
    while (!seen && k < 200) begin
      @(posedge clk);
      #1 k++;
      if (poke && k == 3) begin start = 1'b1; clear_prog = 1'b1; end
      if (poke && k == 4) begin start = 1'b0; clear_prog = 1'b0; end
      if (done) seen = 1'b1;
    end
    got = sb.pop_front();
    chk("done_seen", 32'(seen), 1);
    chk("latency", k, got.lat);
    chk("err_code", 32'(err_code), 32'(got.err));
    chk("err_pc", 32'(err_pc), 32'(got.pc));
    chk("result", 32'(result), 32'(got.res));
    chk("busy_at_done", 32'(busy), 0);
    chk("apply_pulses", n_app - app0, got.apps);
    chk("reset_pulses", n_rst - rst0, got.rsts);
    @(posedge clk);
    #1 chk("done_one_cycle", 32'(done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;
    reset      = 1'b1;
    load_valid = 1'b0;
    load_op    = '0;
    load_data  = '0;
    clear_prog = 1'b0;
    start      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err_code", 32'(err_code), 0);
    chk("rst_err_pc", 32'(err_pc), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_prog_len", 32'(prog_len), 0);
    chk("rst_cq_apply", 32'(cq.cq_apply), 0);
    chk("rst_cq_reset", 32'(cq.cq_reset), 0);

    // PUSH 3, PUSH 4, ADD -> 7 after 8 cycles; mid-run start/clear ignored
    load(OpPush, 8'd3);
    load(OpPush, 8'd4);
    load(OpAdd, 8'd0);
    chk("len_three", 32'(prog_len), 3);
    run(mk(8, 2'd0, 4'd0, 8'd7, 3, 1), 1'b1);
    chk("len_kept_after_run", 32'(prog_len), 3);
    repeat (4) @(posedge clk);
    #1 chk("result_holds", 32'(result), 7);

    // Divide by zero rejected at pc 2
    clear();
    chk("len_cleared", 32'(prog_len), 0);
    load(OpPush, 8'd0);
    load(OpPush, 8'd5);
    load(OpDiv, 8'd0);
    run(mk(8, 2'd1, 4'd2, 8'd0, 3, 1), 1'b0);
    repeat (3) @(posedge clk);
    #1 chk("err_pc_holds", 32'(err_pc), 2);

    // Sixth push overflows the calculator
    clear();
    for (int i = 0; i < 6; i++) load(OpPush, 8'd1);
    run(mk(14, 2'd1, 4'd5, 8'd0, 6, 1), 1'b0);

    // Unassigned opcode 7 is issued as-is and rejected
    clear();
    load(OpPush, 8'd2);
    load(3'd7, 8'd0);
    run(mk(6, 2'd1, 4'd1, 8'd0, 2, 1), 1'b0);

    // Empty program
    clear();
    run(mk(2, 2'd2, 4'd0, 8'd0, 0, 0), 1'b0);

    // Full store refuses a seventeenth word
    clear();
    for (int i = 0; i < 16; i++) load(OpPush, 8'(i));
    chk("len_full", 32'(prog_len), 16);
    @(negedge clk);
    load_valid = 1'b1;
    chk("load_ready_full", 32'(load_ready), 0);
    @(posedge clk);
    #1 load_valid = 1'b0;
    chk("len_stays_full", 32'(prog_len), 16);

    // PUSH 9, POP leaves the queue empty
    clear();
    load(OpPush, 8'd9);
    load(OpPop, 8'd0);
    run(mk(6, 2'd3, 4'd0, 8'd0, 2, 1), 1'b0);

    // Reset while in CHECK aborts with no done pulse
    clear();
    load(OpPush, 8'd3);
    load(OpPush, 8'd4);
    load(OpAdd, 8'd0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_prog_len", 32'(prog_len), 0);
    chk("abort_cq_apply", 32'(cq.cq_apply), 0);
    @(negedge clk);
    reset = 1'b0;
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1 if (done) dn++;
    end
    chk("abort_no_done", dn, 0);
    load(OpPush, 8'd3);
    load(OpPush, 8'd4);
    load(OpAdd, 8'd0);
    run(mk(8, 2'd0, 4'd0, 8'd7, 3, 1), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qcalc_sequencer.md
QCALC_SEQUENCER -- requirements
Module: qcalc_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/result width, equal to the queue calculator WIDTH.
REQ-002 SHALL have parameter PROG_DEPTH, default 16: program store entries (power of 2).
REQ-003 SHALL have clk input, 1 bit: clock, rising edge.
REQ-004 SHALL have reset input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have load_valid input, 1 bit: program word offered.
REQ-006 SHALL have load_ready output, 1 bit: program word accepted this cycle when high with load_valid.
REQ-007 SHALL have load_op input, 3 bits: opcode of offered word.
REQ-008 SHALL have load_data input, WIDTH bits: push operand of offered word.
REQ-009 SHALL have clear_prog input, 1 bit: empty the program store.
REQ-010 SHALL have start input, 1 bit: run the stored program.
REQ-011 SHALL have busy output, 1 bit: run in progress.
REQ-012 SHALL have done output, 1 bit: one-cycle end-of-run pulse.
REQ-013 SHALL have err_code output, 2 bits: 0 ok, 1 rejected op, 2 empty program, 3 empty queue at end.
REQ-014 SHALL have err_pc output, log2(PROG_DEPTH) bits: index of failing instruction.
REQ-015 SHALL have result output, WIDTH bits: calculator tail at successful end.
REQ-016 SHALL have prog_len output, log2(PROG_DEPTH)+1 bits: stored instruction count.
REQ-017 SHALL have cq_reset, cq_apply, cq_op[2:0] and cq_in[WIDTH-1:0] outputs driving the calculator.
REQ-018 SHALL have cq_tail[WIDTH-1:0], cq_valid and cq_empty inputs from the calculator.

Function
REQ-019 SHALL implement states IDLE, CLEAR, ISSUE, CHECK and FINISH.
REQ-020 SHALL drive load_ready = (state==IDLE) && (prog_len<PROG_DEPTH) && !start && !clear_prog.
REQ-021 SHALL write {load_op,load_data} at index prog_len and increment prog_len on load_valid&&load_ready.
REQ-022 SHALL zero prog_len on clear_prog in IDLE; SHALL ignore clear_prog in any other state.
REQ-023 IDLE with start and prog_len==0 SHALL go to FINISH with err_code=2.
REQ-024 IDLE with start and prog_len>0 SHALL go to CLEAR with pc=0 and busy=1.
REQ-025 start outside IDLE SHALL be ignored.
REQ-026 CLEAR SHALL assert cq_reset for exactly one cycle, then go to ISSUE.
REQ-027 ISSUE SHALL assert cq_apply for one cycle with cq_op/cq_in from entry pc, then go to CHECK.
REQ-028 CHECK with cq_valid==0 SHALL go to FINISH with err_code=1 and err_pc=pc.
REQ-029 CHECK with pc==prog_len-1 and cq_empty==1 SHALL go to FINISH with err_code=3.
REQ-030 CHECK with pc==prog_len-1 and cq_empty==0 SHALL go to FINISH with err_code=0 and result=cq_tail.
REQ-031 CHECK in any other case SHALL increment pc and return to ISSUE.
REQ-032 FINISH SHALL pulse done for one cycle, clear busy and return to IDLE.
REQ-033 err_code, err_pc and result SHALL hold until the next start.
REQ-034 Latency SHALL be 2+2*prog_len cycles from the start edge to done high.
REQ-035 Opcodes 7 SHALL be issued unmodified; the calculator rejection SHALL then give err_code=1.
REQ-036 cq_apply and cq_reset SHALL be 0 in all states other than ISSUE and CLEAR respectively.

Reset
REQ-037 reset SHALL force IDLE with pc=0, prog_len=0, busy=0, done=0, err_code=0, err_pc=0, result=0, cq_apply=0 and cq_reset=0.
REQ-038 reset mid-run SHALL abort without a done pulse; the program store contents SHALL NOT be cleared.

Configuration
REQ-039 With QSEQ_STEP_EN defined, the block SHALL add inputs step_mode and step.
REQ-040 With QSEQ_STEP_EN defined and step_mode=1, ISSUE SHALL wait until step=1 before asserting cq_apply.
REQ-041 Without QSEQ_STEP_EN, the step ports SHALL be absent and the block SHALL run freely.

Structure
REQ-042 Package qcalc_pkg SHALL hold the opcode enum (PUSH=0, POP=1, ADD=2, MUL=3, SUB=4, DIV=5, MOD=6), the state enum, the err_code enum and the program word struct.
REQ-043 Sub-module qseq_prog_mem SHALL implement the PROG_DEPTH x (3+WIDTH) register file: one write port and one combinational read port.

Verification
REQ-044 Load PUSH 3, PUSH 4, ADD then start -> done 8 cycles later, result=7, err_code=0.
REQ-045 Load PUSH 0, PUSH 5, DIV then start -> err_code=1, err_pc=2.
REQ-046 Load 6x PUSH 1 then start -> err_code=1, err_pc=5.
REQ-047 Start with an empty program -> done 2 cycles later, err_code=2.
REQ-048 Load 16 words -> load_ready=0 on the 17th; load PUSH 9, POP then start -> err_code=3.
REQ-049 Assert reset during CHECK -> busy=0 and no done pulse; rerun with start -> same result as an uninterrupted run.
